// File: rtl/int_issue_queue_if.sv
// int_issue_queue_if: entry-array interface published to the scheduler, plus shared ALU-control type.
`ifndef INT_QUEUE_SIZE
`define INT_QUEUE_SIZE 8
`endif
`ifndef INT_QUEUE_SIZE_INDEX
`define INT_QUEUE_SIZE_INDEX 3
`endif
`ifndef INT_IQ_TYPES
`define INT_IQ_TYPES
typedef logic [3:0] alu_ctl_t;
`endif

interface integer_issue_queue_ifc #(
    parameter int QUEUE_SIZE = `INT_QUEUE_SIZE,
    parameter int PREG_INDEX = 6,
    parameter int AL_INDEX   = 5,
    parameter int DATA_WIDTH = 32
);
    logic [QUEUE_SIZE-1:0] entry_available_bit, ready_bit_src1, ready_bit_src2;
    logic [QUEUE_SIZE-1:0] uses_rs, uses_rt, uses_immediate, is_branch, prediction;
    logic [PREG_INDEX-1:0] src1 [QUEUE_SIZE];
    logic [PREG_INDEX-1:0] src2 [QUEUE_SIZE];
    logic [DATA_WIDTH-1:0] immediate_data [QUEUE_SIZE];
    logic [DATA_WIDTH-1:0] recovery_target [QUEUE_SIZE];
    alu_ctl_t alu_ctl [QUEUE_SIZE];
    logic [AL_INDEX-1:0] active_list_id [QUEUE_SIZE];

    modport out (output entry_available_bit, ready_bit_src1, ready_bit_src2, uses_rs, uses_rt,
                 uses_immediate, is_branch, prediction, src1, src2, immediate_data,
                 recovery_target, alu_ctl, active_list_id);
    modport in  (input  entry_available_bit, ready_bit_src1, ready_bit_src2, uses_rs, uses_rt,
                 uses_immediate, is_branch, prediction, src1, src2, immediate_data,
                 recovery_target, alu_ctl, active_list_id);
endinterface

// File: rtl/int_issue_queue.sv
// int_issue_queue: integer issue-queue storage with tag-broadcast wakeup, issue free and flush.
// Optional INT_IQ_MEM_WAKEUP_EN lets load writeback broadcasts wake and bypass sources.
`ifndef INT_QUEUE_SIZE
`define INT_QUEUE_SIZE 8
`endif
`ifndef INT_QUEUE_SIZE_INDEX
`define INT_QUEUE_SIZE_INDEX 3
`endif
`ifndef INT_IQ_TYPES
`define INT_IQ_TYPES
typedef logic [3:0] alu_ctl_t;
`endif

module int_issue_queue #(
    parameter int QUEUE_SIZE  = `INT_QUEUE_SIZE,
    parameter int QUEUE_INDEX = `INT_QUEUE_SIZE_INDEX,
    parameter int PREG_INDEX  = 6,
    parameter int AL_INDEX    = 5,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    alloc_valid,
    output logic                    alloc_ready,
    input  logic [PREG_INDEX-1:0]   alloc_src1,
    input  logic [PREG_INDEX-1:0]   alloc_src2,
    input  logic                    alloc_src1_ready,
    input  logic                    alloc_src2_ready,
    input  logic                    alloc_uses_rs,
    input  logic                    alloc_uses_rt,
    input  logic                    alloc_uses_immediate,
    input  logic                    alloc_is_branch,
    input  logic                    alloc_prediction,
    input  alu_ctl_t                alloc_alu_ctl,
    input  logic [DATA_WIDTH-1:0]   alloc_immediate,
    input  logic [DATA_WIDTH-1:0]   alloc_recovery_target,
    input  logic [AL_INDEX-1:0]     alloc_active_list_id,
    input  logic                    issue_valid,
    input  logic [QUEUE_INDEX-1:0]  issue_index,
    input  logic                    wake_alu_valid,
    input  logic [PREG_INDEX-1:0]   wake_alu_tag,
    input  logic                    wake_mem_valid,
    input  logic [PREG_INDEX-1:0]   wake_mem_tag,
    input  logic                    flush,
    output logic [QUEUE_INDEX:0]    occupancy,
    integer_issue_queue_ifc.out     o_queue
);
    logic [QUEUE_SIZE-1:0]  free;
    logic [QUEUE_INDEX-1:0] idx;
    logic                   alloc_do;

    assign free        = o_queue.entry_available_bit;
    assign alloc_ready = |free;
    assign alloc_do    = alloc_valid & alloc_ready & ~flush;

`ifndef INT_IQ_MEM_WAKEUP_EN
    logic unused_mem;
    assign unused_mem = ^{wake_mem_valid, wake_mem_tag};
`endif

    // Tag 0 is $zero and never participates in broadcast matching.
    function automatic logic woke(input logic [PREG_INDEX-1:0] t);
`ifdef INT_IQ_MEM_WAKEUP_EN
        return (|t) && ((wake_alu_valid && t == wake_alu_tag) || (wake_mem_valid && t == wake_mem_tag));
`else
        return (|t) && wake_alu_valid && t == wake_alu_tag;
`endif
    endfunction

    always_comb begin
        idx = '0;
        for (int i = QUEUE_SIZE - 1; i >= 0; i--)
            idx = free[i] ? i[QUEUE_INDEX-1:0] : idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_queue.entry_available_bit <= '1;
            o_queue.ready_bit_src1      <= '0;
            o_queue.ready_bit_src2      <= '0;
            o_queue.uses_rs             <= '0;
            o_queue.uses_rt             <= '0;
            o_queue.uses_immediate      <= '0;
            o_queue.is_branch           <= '0;
            o_queue.prediction          <= '0;
            for (int i = 0; i < QUEUE_SIZE; i++) begin
                o_queue.src1[i]            <= '0;
                o_queue.src2[i]            <= '0;
                o_queue.immediate_data[i]  <= '0;
                o_queue.recovery_target[i] <= '0;
                o_queue.alu_ctl[i]         <= '0;
                o_queue.active_list_id[i]  <= '0;
            end
            occupancy <= '0;
        end else if (flush) begin
            o_queue.entry_available_bit <= '1;
            occupancy                   <= '0;
        end else begin
            for (int i = 0; i < QUEUE_SIZE; i++) begin
                if (!free[i] && woke(o_queue.src1[i])) o_queue.ready_bit_src1[i] <= 1'b1;
                if (!free[i] && woke(o_queue.src2[i])) o_queue.ready_bit_src2[i] <= 1'b1;
            end
            if (issue_valid) o_queue.entry_available_bit[issue_index] <= 1'b1;
            if (alloc_do) begin
                o_queue.entry_available_bit[idx] <= 1'b0;
                o_queue.ready_bit_src1[idx]      <= alloc_src1_ready | ~alloc_uses_rs | woke(alloc_src1);
                o_queue.ready_bit_src2[idx]      <= alloc_src2_ready | ~alloc_uses_rt | alloc_uses_immediate | woke(alloc_src2);
                o_queue.uses_rs[idx]             <= alloc_uses_rs;
                o_queue.uses_rt[idx]             <= alloc_uses_rt;
                o_queue.uses_immediate[idx]      <= alloc_uses_immediate;
                o_queue.is_branch[idx]           <= alloc_is_branch;
                o_queue.prediction[idx]          <= alloc_prediction;
                o_queue.src1[idx]                <= alloc_src1;
                o_queue.src2[idx]                <= alloc_src2;
                o_queue.immediate_data[idx]      <= alloc_immediate;
                o_queue.recovery_target[idx]     <= alloc_recovery_target;
                o_queue.alu_ctl[idx]             <= alloc_alu_ctl;
                o_queue.active_list_id[idx]      <= alloc_active_list_id;
            end
            occupancy <= occupancy + (QUEUE_INDEX+1)'(alloc_do) - (QUEUE_INDEX+1)'(issue_valid);
        end
    end

    // The scheduler must only issue occupied entries.
    assert property (@(posedge clk) disable iff (!rst_n) issue_valid && !flush |-> !free[issue_index]);
endmodule

// File: tb/tb_int_issue_queue.sv
// tb_int_issue_queue: table-driven fill/issue/flush vectors plus directed wakeup, bypass and reset sequences.
module tb_int_issue_queue;
    logic       clk = 0, rst_n = 0;
    logic       alloc_valid, alloc_ready, alloc_src1_ready, alloc_src2_ready;
    logic [5:0] alloc_src1, alloc_src2, wake_alu_tag, wake_mem_tag;
    logic       alloc_uses_rs, alloc_uses_rt, alloc_uses_immediate, alloc_is_branch, alloc_prediction;
    logic [3:0] alloc_alu_ctl;
    logic [31:0] alloc_immediate, alloc_recovery_target;
    logic [4:0] alloc_active_list_id;
    logic       issue_valid, wake_alu_valid, wake_mem_valid, flush;
    logic [2:0] issue_index;
    logic [3:0] occupancy;
    int checks = 0, errors = 0;

    integer_issue_queue_ifc #(.QUEUE_SIZE(8), .PREG_INDEX(6), .AL_INDEX(5), .DATA_WIDTH(32)) q ();

    int_issue_queue dut (
        .clk(clk), .rst_n(rst_n), .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_src1(alloc_src1), .alloc_src2(alloc_src2),
        .alloc_src1_ready(alloc_src1_ready), .alloc_src2_ready(alloc_src2_ready),
        .alloc_uses_rs(alloc_uses_rs), .alloc_uses_rt(alloc_uses_rt),
        .alloc_uses_immediate(alloc_uses_immediate), .alloc_is_branch(alloc_is_branch),
        .alloc_prediction(alloc_prediction), .alloc_alu_ctl(alloc_alu_ctl),
        .alloc_immediate(alloc_immediate), .alloc_recovery_target(alloc_recovery_target),
        .alloc_active_list_id(alloc_active_list_id), .issue_valid(issue_valid),
        .issue_index(issue_index), .wake_alu_valid(wake_alu_valid), .wake_alu_tag(wake_alu_tag),
        .wake_mem_valid(wake_mem_valid), .wake_mem_tag(wake_mem_tag), .flush(flush),
        .occupancy(occupancy), .o_queue(q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       av;
        logic [5:0] s1;
        logic       iv;
        logic [2:0] ii;
        logic       fl;
        logic [3:0] occ;
        logic       rdy;
        logic [7:0] free;
    } vec_t;
    vec_t v[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid = 0; issue_valid = 0; wake_alu_valid = 0; wake_mem_valid = 0; flush = 0;
        issue_index = 0; wake_alu_tag = 0; wake_mem_tag = 0;
    endtask

    task automatic alloc(input logic [5:0] s1, input logic r1, input logic urs,
                         input logic [5:0] s2, input logic r2, input logic urt, input logic uimm);
        idle();
        alloc_valid = 1; alloc_src1 = s1; alloc_src1_ready = r1; alloc_uses_rs = urs;
        alloc_src2 = s2; alloc_src2_ready = r2; alloc_uses_rt = urt; alloc_uses_immediate = uimm;
    endtask

    initial begin
        logic mem_exp;
`ifdef INT_IQ_MEM_WAKEUP_EN
        mem_exp = 1;
`else
        mem_exp = 0;
`endif
        for (int k = 0; k < 8; k++)
            v[k] = '{1, 6'(10 + k), 0, 0, 0, 4'(k + 1), k < 7, 8'hff << (k + 1)};
        v[8]  = '{1, 40, 0, 0, 0, 8, 0, 8'h00};
        v[9]  = '{1, 41, 1, 3, 0, 7, 1, 8'h08};
        v[10] = '{1, 50, 0, 0, 0, 8, 0, 8'h00};
        v[11] = '{1, 51, 1, 5, 1, 0, 1, 8'hff};

        idle();
        alloc_src1 = 0; alloc_src2 = 0; alloc_src1_ready = 1; alloc_src2_ready = 1;
        alloc_uses_rs = 1; alloc_uses_rt = 1; alloc_uses_immediate = 0; alloc_is_branch = 0;
        alloc_prediction = 0; alloc_alu_ctl = 4'h3; alloc_immediate = 32'h1234;
        alloc_recovery_target = 32'h400; alloc_active_list_id = 5'd7;
        #8;
        chk("reset_free", q.entry_available_bit, 8'hff);
        chk("reset_occ", occupancy, 0);
        chk("reset_rdy", alloc_ready, 1);
        chk("reset_rb", {q.ready_bit_src1, q.ready_bit_src2}, 0);
        #4 rst_n = 1;

        for (int k = 0; k < 12; k++) begin
            alloc_valid = v[k].av; alloc_src1 = v[k].s1; issue_valid = v[k].iv;
            issue_index = v[k].ii; flush = v[k].fl;
            if (v[k].iv && !v[k].fl) chk("rdy_ignores_issue", alloc_ready, v[k].occ == 7 ? 0 : 1);
            step();
            chk($sformatf("v%0d_occ", k), occupancy, v[k].occ);
            chk($sformatf("v%0d_rdy", k), alloc_ready, v[k].rdy);
            chk($sformatf("v%0d_free", k), q.entry_available_bit, v[k].free);
        end
        for (int i = 0; i < 8; i++)
            chk($sformatf("src1_e%0d", i), q.src1[i], i == 3 ? 50 : 10 + i);
        chk("imm_e0", q.immediate_data[0], 32'h1234);

        alloc(12, 0, 1, 5, 1, 1, 0);
        step();
        chk("wake_c1", q.ready_bit_src1[0], 0);
        alloc(7, 1, 1, 12, 0, 1, 0);
        step();
        alloc(13, 0, 1, 3, 1, 1, 0);
        step();
        alloc(0, 0, 1, 3, 1, 1, 0);
        step();
        chk("wake_pre", {q.ready_bit_src1[0], q.ready_bit_src2[1]}, 0);
        idle(); wake_alu_valid = 1; wake_alu_tag = 12;
        step();
        chk("wake_src1", q.ready_bit_src1[0], 1);
        chk("wake_src2", q.ready_bit_src2[1], 1);
        chk("wake_other", q.ready_bit_src1[2], 0);
        idle(); wake_alu_valid = 1; wake_alu_tag = 0;
        step();
        chk("wake_tag0", q.ready_bit_src1[3], 0);

        alloc(21, 1, 1, 20, 0, 1, 0); wake_alu_valid = 1; wake_alu_tag = 20;
        step();
        chk("bypass_src2", q.ready_bit_src2[4], 1);
        alloc(30, 0, 0, 31, 0, 1, 1);
        step();
        chk("unused_src1", q.ready_bit_src1[5], 1);
        chk("imm_src2", q.ready_bit_src2[5], 1);
        chk("occ6", occupancy, 6);

        idle(); issue_valid = 1; issue_index = 0;
        step();
        chk("issue_free", q.entry_available_bit, 8'hc1);
        chk("issue_occ", occupancy, 5);
        alloc(33, 1, 1, 34, 1, 1, 0); issue_valid = 1; issue_index = 1; flush = 1;
        step();
        chk("flush_free", q.entry_available_bit, 8'hff);
        chk("flush_occ", occupancy, 0);

        alloc(9, 0, 1, 2, 1, 1, 0);
        step();
        chk("mem_pre", q.ready_bit_src1[0], 0);
        idle(); wake_mem_valid = 1; wake_mem_tag = 9;
        step();
        chk("mem_wake", q.ready_bit_src1[0], mem_exp);
        idle();

        #3 rst_n = 0;
        #1;
        chk("async_free", q.entry_available_bit, 8'hff);
        chk("async_occ", occupancy, 0);
        chk("async_src1", q.src1[0], 0);
        chk("async_rdy", alloc_ready, 1);
        #1 rst_n = 1;
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/int_issue_queue.md
# int_issue_queue

Integer issue queue storage block: the writer side of the integer issue-queue interface that the scheduler reads. It accepts renamed integer/branch instructions from dispatch, holds them in a fixed number of entries, and tracks per-source ready bits via tag-broadcast wakeup. It frees the entry the scheduler selects each cycle and clears everything on a pipeline flush. It publishes the full entry array on `integer_issue_queue_ifc.out`, from which the scheduler selects and issues the next ready entry.

## Interface
- `QUEUE_SIZE`, default `` `INT_QUEUE_SIZE `` (8): number of entries.
- `QUEUE_INDEX`, default `` `INT_QUEUE_SIZE_INDEX `` (3): entry index width.
- `PREG_INDEX`, default 6: physical register tag width.
- `AL_INDEX`, default 5: active-list id width.
- `DATA_WIDTH`, default 32: immediate / recovery target width.

Ports:
- `clk  in  1`: clock.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `alloc_valid  in  1`: dispatch offers an instruction.
- `alloc_ready  out  1`: at least one free entry this cycle.
- `alloc_src1`, `alloc_src2  in  PREG_INDEX`: source tags.
- `alloc_src1_ready`, `alloc_src2_ready  in  1`: source ready bits from the rename busy table.
- `alloc_uses_rs`, `alloc_uses_rt`, `alloc_uses_immediate`, `alloc_is_branch`, `alloc_prediction  in  1`: decode flags.
- `alloc_alu_ctl  in  alu_ctl_t`: ALU operation.
- `alloc_immediate`, `alloc_recovery_target  in  DATA_WIDTH`: immediate value and branch recovery target.
- `alloc_active_list_id  in  AL_INDEX`: active-list id of the instruction.
- `issue_valid  in  1`: scheduler dispatched an entry this cycle.
- `issue_index  in  QUEUE_INDEX`: index of the dispatched entry.
- `wake_alu_valid  in  1`, `wake_alu_tag  in  PREG_INDEX`: ALU writeback broadcast.
- `wake_mem_valid  in  1`, `wake_mem_tag  in  PREG_INDEX`: load writeback broadcast (see Configuration).
- `flush  in  1`: misprediction or exception flush.
- `occupancy  out  QUEUE_INDEX+1`: number of occupied entries (registered).
- `o_queue  integer_issue_queue_ifc.out`: per-entry `entry_available_bit`, `ready_bit_src1/2`, `src1/2`, `uses_rs/rt/immediate`, `immediate_data`, `alu_ctl`, `is_branch`, `prediction`, `recovery_target`, `active_list_id`. All fields are registered.

## Operation
- **Allocation**
  - Free vector = registered `entry_available_bit`.
  - Target = lowest-index free entry, selected by the bottom-up priority encoder.
  - `alloc_ready` = OR of the free vector. It is combinational from state only and never depends on `issue_valid`.
  - Write happens when `alloc_valid & alloc_ready & !flush`. The target entry gets all fields and `entry_available_bit` = 0.
  - `alloc_valid` while not ready is ignored; dispatch holds the instruction.
- **Ready bits at allocation**
  - `ready_bit_srcN` = `alloc_srcN_ready`, OR the operand is unused (`!uses_rs` for src1, `!uses_rt | uses_immediate` for src2), OR the tag matches an enabled wakeup in the same cycle (bypass).
- **Wakeup**
  - Each occupied entry whose `srcN` equals an enabled broadcast tag gets `ready_bit_srcN` = 1 at the next edge.
  - Tag 0 is never broadcast-matched; `$zero` is always ready via the unused-operand rule.
- **Issue**
  - `issue_valid` sets `entry_available_bit[issue_index]` = 1 at the next edge.
  - Issuing an already-free entry is a protocol error and is flagged by an assertion.
  - The freed slot becomes allocatable the cycle after.
- **Same cycle events**
  - Allocation and issue never target the same index, because allocation uses only currently free entries.
  - Wakeup may target an entry being issued; the harmless ready write is kept.
- **Flush**
  - All entries become available at the next edge.
  - `occupancy` goes to 0.
  - Allocation, issue and wakeup in the flush cycle are discarded.
- **Occupancy counter**
  - Next value = current + (alloc accepted) − (issue_valid). It is 0 on flush.
  - It never exceeds `QUEUE_SIZE`.

## Timing
- **Reset** (`rst_n` low, asynchronous):
  - All `entry_available_bit` = 1.
  - All ready bits = 0.
  - All payload fields = 0.
  - `occupancy` = 0 and `alloc_ready` = 1.
  - Reset asserted mid-operation drops all entries immediately.
- **Latencies**
  - Allocate → visible to the scheduler: 1 cycle.
  - Wakeup → ready bit set: 1 cycle, so a back-to-back dependent issues in the cycle after the producer's writeback.
  - Issue → entry free: 1 cycle.
  - Flush → empty: 1 cycle.
- **Full**: when `occupancy` = `QUEUE_SIZE`, `alloc_ready` = 0. A simultaneous issue does not reopen allocation until the next cycle.

## Configuration
- Macro: `INT_IQ_MEM_WAKEUP_EN`.
- **Defined**: the `wake_mem_*` port participates in both wakeup and allocation bypass, so load consumers wake directly from load writeback.
- **Undefined**: `wake_mem_*` is ignored (port retained, unconnected internally). Only ALU broadcasts set ready bits, and load-dependent readiness comes only from `alloc_srcN_ready`.

## Test plan
- Reset, then allocate 8 instructions with all sources ready → entries 0..7 filled in order, `occupancy` = 8, `alloc_ready` = 0; a 9th `alloc_valid` is ignored.
- Full queue, `issue_valid` with `issue_index` = 3 → next cycle entry 3 is free, `alloc_ready` = 1; the next allocation lands in entry 3.
- Allocate an instruction with src1 = 12 not ready, then `wake_alu_tag` = 12 → `ready_bit_src1` is 0 in cycle 1 and 1 in cycle 2; an entry with src2 = 12 also wakes.
- Allocate with src2 = 20 not ready in the same cycle as `wake_alu_tag` = 20 → the entry is written with `ready_bit_src2` = 1.
- Five entries occupied, `flush` together with `alloc_valid` and `issue_valid` → next cycle all entries are free, `occupancy` = 0, and the flush-cycle allocation is dropped.
- `wake_mem_tag` = 9 against a waiting src1 = 9 → ready after 1 cycle with `INT_IQ_MEM_WAKEUP_EN`; stays 0 without it.
